// File: rtl/imm_move_sequencer_if.sv
// Request/response stream bundle for imm_move_sequencer: a 64-bit constant plus Rd in,
// one 32-bit MOVZ/MOVK/MOVN word per beat out.
interface imm_move_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] Value;
    logic [4:0]  Rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Instruction;
    logic        out_last;
    logic        busy;

    modport slave (
        input  in_valid, Value, Rd, out_ready,
        output in_ready, out_valid, Instruction, out_last, busy
    );

    modport master (
        output in_valid, Value, Rd, out_ready,
        input  in_ready, out_valid, Instruction, out_last, busy
    );
endinterface

// File: rtl/imm_move_sequencer.sv
// Turns a 64-bit constant and Rd into the shortest MOVZ/MOVK sequence, one word per beat.
// Define MOVN_INVERT_EN to start mostly-ones constants with MOVN instead of MOVZ.
module imm_move_sequencer #(
    parameter bit EMIT_ZERO_HW = 1'b0
) (
    input  logic                  CLK,
    input  logic                  resetl,
    imm_move_sequencer_if.slave   bus
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [8:0] OPC_MOVZ = 9'b110100101;
    localparam logic [8:0] OPC_MOVK = 9'b111100101;
`ifdef MOVN_INVERT_EN
    localparam logic [8:0] OPC_MOVN = 9'b100100101;
`endif

    state_t      state_q, state_d;
    logic [63:0] val_q, val_d;
    logic [4:0]  rd_q, rd_d;
    logic [3:0]  rem_q, rem_d;
    logic [31:0] instr_q, instr_d;
    logic        vld_q, vld_d;
    logic        last_q, last_d;

    logic [3:0]  nz_mask;
    logic [3:0]  acc_mask;
    logic [3:0]  acc_rest;
    logic [1:0]  acc_idx;
    logic [15:0] acc_hw;
    logic        acc_inv;
    logic [1:0]  nxt_idx;
    logic [3:0]  nxt_rest;

    function automatic logic [15:0] halfword(input logic [63:0] v, input logic [1:0] i);
        logic [15:0] h;
        case (i)
            2'd0:    h = v[15:0];
            2'd1:    h = v[31:16];
            2'd2:    h = v[47:32];
            default: h = v[63:48];
        endcase
        return h;
    endfunction

    // An empty mask maps to index 0, which yields the MOVZ #0 / MOVN #0 single-word forms.
    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] r;
        casez (m)
            4'b???1: r = 2'd0;
            4'b??10: r = 2'd1;
            4'b?100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] encode(input logic [8:0] opc, input logic [1:0] hw,
                                           input logic [15:0] imm, input logic [4:0] rd);
        return {opc, hw, imm, rd};
    endfunction

    always_comb begin
        acc_inv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nz_mask[i] = (bus.Value[16*i +: 16] != 16'h0000);
        end
`ifdef MOVN_INVERT_EN
        begin
            logic [3:0] nf_mask;
            for (int i = 0; i < 4; i++) begin
                nf_mask[i] = (bus.Value[16*i +: 16] != 16'hFFFF);
            end
            acc_inv = !EMIT_ZERO_HW && ($countones(~nf_mask) > $countones(~nz_mask));
            acc_mask = EMIT_ZERO_HW ? 4'b1111 : (acc_inv ? nf_mask : nz_mask);
        end
`else
        acc_mask = EMIT_ZERO_HW ? 4'b1111 : nz_mask;
`endif
        acc_idx  = lowest_idx(acc_mask);
        acc_hw   = halfword(bus.Value, acc_idx);
        acc_rest = acc_mask & ~(4'b0001 << acc_idx);
        nxt_idx  = lowest_idx(rem_q);
        nxt_rest = rem_q & ~(4'b0001 << nxt_idx);
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        rd_d    = rd_q;
        rem_d   = rem_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    val_d   = bus.Value;
                    rd_d    = bus.Rd;
                    rem_d   = acc_rest;
                    instr_d = acc_inv ? encode(9'b100100101, acc_idx, ~acc_hw, bus.Rd)
                                      : encode(OPC_MOVZ, acc_idx, acc_hw, bus.Rd);
                    vld_d   = 1'b1;
                    last_d  = (acc_rest == 4'b0000);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                // out_valid is always high in EMIT, so out_ready alone marks a transfer.
                if (bus.out_ready) begin
                    if (rem_q != 4'b0000) begin
                        instr_d = encode(OPC_MOVK, nxt_idx, halfword(val_q, nxt_idx), rd_q);
                        rem_d   = nxt_rest;
                        last_d  = (nxt_rest == 4'b0000);
                    end else begin
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            rem_q   <= 4'b0000;
            instr_q <= 32'h0000_0000;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge CLK) begin
        val_q <= val_d;
        rd_q  <= rd_d;
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_valid   = vld_q;
    assign bus.Instruction = instr_q;
    assign bus.out_last    = last_q;

endmodule

// File: tb/tb_imm_move_sequencer.sv
// Directed bench for imm_move_sequencer: default instance plus an EMIT_ZERO_HW=1 instance.
module tb_imm_move_sequencer;

    logic CLK;
    logic resetl;
    int   total;
    int   bad;

    logic [31:0] got_w [4];
    logic        got_l [4];
    int          got_n;

    imm_move_sequencer_if if0 ();
    imm_move_sequencer_if if1 ();

    imm_move_sequencer #(.EMIT_ZERO_HW(1'b0)) dut  (.CLK(CLK), .resetl(resetl), .bus(if0));
    imm_move_sequencer #(.EMIT_ZERO_HW(1'b1)) dutz (.CLK(CLK), .resetl(resetl), .bus(if1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue0(input logic [63:0] v, input logic [4:0] rd);
        int c;
        c = 0;
        while (!if0.in_ready && c < 20) begin
            step();
            c++;
        end
        if (!if0.in_ready) begin
            total++; bad++;
            $display("FAIL issue_wait: in_ready=%0b after %0d cycles, required 1", if0.in_ready, c);
        end
        if0.Value    = v;
        if0.Rd       = rd;
        if0.in_valid = 1'b1;
        step();
        if0.in_valid = 1'b0;
        if0.Value    = 64'h0;
        if0.Rd       = 5'd0;
    endtask

    task automatic collect0();
        got_n = 0;
        if0.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (if0.out_valid) begin
                if (got_n < 4) begin
                    got_w[got_n] = if0.Instruction;
                    got_l[got_n] = if0.out_last;
                end
                got_n++;
                if (if0.out_last) begin
                    step();
                    return;
                end
            end
            step();
        end
        total++; bad++;
        $display("FAIL collect_timeout: words=%0d without out_last, required a last word", got_n);
    endtask

    task automatic test_reset();
        resetl = 1'b0;
        step();
        step();
        total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", if0.out_valid); end
        total++; if (if0.Instruction !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 00000000", if0.Instruction); end
        total++; if (if0.out_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %0b want 0", if0.out_last); end
        total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", if0.busy); end
        total++; if (if0.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b want 1", if0.in_ready); end
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL rst_z_out_valid: got %0b want 0", if1.out_valid); end
        resetl = 1'b1;
        step();
    endtask

    task automatic test_zero();
        if0.Value = 64'h0; if0.Rd = 5'd0; if0.in_valid = 1'b1; if0.out_ready = 1'b1;
        step();
        if0.in_valid = 1'b0;
        total++; if (if0.out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid: got %0b want 1", if0.out_valid); end
        total++; if (if0.Instruction !== 32'hD280_0000) begin bad++; $display("FAIL zero_word: got %h want d2800000", if0.Instruction); end
        total++; if (if0.out_last !== 1'b1) begin bad++; $display("FAIL zero_last: got %0b want 1", if0.out_last); end
        total++; if (if0.in_ready !== 1'b0) begin bad++; $display("FAIL zero_in_ready_busy: got %0b want 0", if0.in_ready); end
        total++; if (if0.busy !== 1'b1) begin bad++; $display("FAIL zero_busy: got %0b want 1", if0.busy); end
        step();
        total++; if (if0.in_ready !== 1'b1) begin bad++; $display("FAIL zero_in_ready_after: got %0b want 1", if0.in_ready); end
        total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid_after: got %0b want 0", if0.out_valid); end
    endtask

    task automatic test_single();
        issue0(64'h0000_0000_0000_1234, 5'd1);
        collect0();
        total++; if (got_n !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", got_n); end
        total++; if (got_w[0] !== 32'hD282_4681) begin bad++; $display("FAIL single_word: got %h want d2824681", got_w[0]); end
        total++; if (got_l[0] !== 1'b1) begin bad++; $display("FAIL single_last: got %0b want 1", got_l[0]); end
    endtask

    task automatic test_two();
        issue0(64'h0000_5678_0000_1234, 5'd2);
        collect0();
        total++; if (got_n !== 2) begin bad++; $display("FAIL two_count: got %0d want 2", got_n); end
        total++; if (got_w[0] !== 32'hD282_4682) begin bad++; $display("FAIL two_w0: got %h want d2824682", got_w[0]); end
        total++; if (got_l[0] !== 1'b0) begin bad++; $display("FAIL two_l0: got %0b want 0", got_l[0]); end
        total++; if (got_w[1] !== 32'hF2CA_CF02) begin bad++; $display("FAIL two_w1: got %h want f2cacf02", got_w[1]); end
        total++; if (got_l[1] !== 1'b1) begin bad++; $display("FAIL two_l1: got %0b want 1", got_l[1]); end
    endtask

    task automatic test_hold();
        if0.out_ready = 1'b0;
        issue0(64'hFFFF_0000_0000_0000, 5'd3);
        for (int c = 0; c < 4; c++) begin
            total++; if (if0.out_valid !== 1'b1 || if0.Instruction !== 32'hD2FF_FFE3 || if0.out_last !== 1'b1)
                begin bad++; $display("FAIL hold_c%0d: valid=%0b word=%h last=%0b want 1 d2ffffe3 1", c, if0.out_valid, if0.Instruction, if0.out_last); end
            total++; if (if0.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready_c%0d: got %0b want 0", c, if0.in_ready); end
            if (c < 3) begin
                if0.in_valid = 1'b1; if0.Value = 64'hAAAA_5555_AAAA_5555; if0.Rd = 5'd9;
            end else begin
                if0.in_valid = 1'b0; if0.Value = 64'h0; if0.out_ready = 1'b1;
            end
            step();
        end
        total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL hold_no_repeat: out_valid=%0b want 0", if0.out_valid); end
        total++; if (if0.in_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_after: got %0b want 1", if0.in_ready); end
        step();
        total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL hold_ignored_req: out_valid=%0b want 0", if0.out_valid); end
    endtask

    task automatic test_back_to_back();
        if0.out_ready = 1'b1;
        if0.Value = 64'h0000_0000_0000_1234; if0.Rd = 5'd1; if0.in_valid = 1'b1;
        step();
        total++; if (if0.Instruction !== 32'hD282_4681) begin bad++; $display("FAIL b2b_first: got %h want d2824681", if0.Instruction); end
        if0.Value = 64'h0000_0000_0001_0000; if0.Rd = 5'd5;
        step();
        total++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1)
            begin bad++; $display("FAIL b2b_gap: valid=%0b in_ready=%0b want 0 1", if0.out_valid, if0.in_ready); end
        step();
        if0.in_valid = 1'b0;
        total++; if (if0.out_valid !== 1'b1 || if0.Instruction !== 32'hD2A0_0025 || if0.out_last !== 1'b1)
            begin bad++; $display("FAIL b2b_second: valid=%0b word=%h last=%0b want 1 d2a00025 1", if0.out_valid, if0.Instruction, if0.out_last); end
        step();
        total++; if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got %0b want 0", if0.out_valid); end
    endtask

    task automatic test_movn();
        issue0(64'hFFFF_FFFF_FFFF_1234, 5'd4);
        collect0();
`ifdef MOVN_INVERT_EN
        total++; if (got_n !== 1) begin bad++; $display("FAIL movn_count: got %0d want 1", got_n); end
        total++; if (got_w[0] !== 32'h929D_B964) begin bad++; $display("FAIL movn_word: got %h want 929db964", got_w[0]); end
        issue0(64'hFFFF_FFFF_FFFF_FFFF, 5'd4);
        collect0();
        total++; if (got_n !== 1 || got_w[0] !== 32'h9280_0004)
            begin bad++; $display("FAIL movn_ones: count=%0d word=%h want 1 92800004", got_n, got_w[0]); end
`else
        total++; if (got_n !== 4) begin bad++; $display("FAIL movz_count: got %0d want 4", got_n); end
        total++; if (got_w[0] !== 32'hD282_4684) begin bad++; $display("FAIL movz_w0: got %h want d2824684", got_w[0]); end
        total++; if (got_w[1] !== 32'hF2BF_FFE4) begin bad++; $display("FAIL movz_w1: got %h want f2bfffe4", got_w[1]); end
        total++; if (got_w[3] !== 32'hF2FF_FFE4 || got_l[3] !== 1'b1)
            begin bad++; $display("FAIL movz_w3: word=%h last=%0b want f2ffffe4 1", got_w[3], got_l[3]); end
        issue0(64'hFFFF_FFFF_FFFF_FFFF, 5'd4);
        collect0();
        total++; if (got_n !== 4 || got_w[0] !== 32'hD29F_FFE4)
            begin bad++; $display("FAIL movz_ones: count=%0d word=%h want 4 d29fffe4", got_n, got_w[0]); end
`endif
    endtask

    task automatic test_zero_hw();
        if1.out_ready = 1'b1;
        if1.Value = 64'h0000_0000_0000_1234; if1.Rd = 5'd1; if1.in_valid = 1'b1;
        step();
        if1.in_valid = 1'b0; if1.Value = 64'h0;
        total++; if (if1.Instruction !== 32'hD282_4681 || if1.out_last !== 1'b0)
            begin bad++; $display("FAIL zhw_w0: word=%h last=%0b want d2824681 0", if1.Instruction, if1.out_last); end
        step();
        total++; if (if1.Instruction !== 32'hF2A0_0001 || if1.out_last !== 1'b0)
            begin bad++; $display("FAIL zhw_w1: word=%h last=%0b want f2a00001 0", if1.Instruction, if1.out_last); end
        step();
        total++; if (if1.Instruction !== 32'hF2C0_0001 || if1.out_last !== 1'b0)
            begin bad++; $display("FAIL zhw_w2: word=%h last=%0b want f2c00001 0", if1.Instruction, if1.out_last); end
        resetl = 1'b0;
        #1;
        total++; if (if1.out_valid !== 1'b0 || if1.Instruction !== 32'h0 || if1.busy !== 1'b0)
            begin bad++; $display("FAIL zhw_abort: valid=%0b word=%h busy=%0b want 0 00000000 0", if1.out_valid, if1.Instruction, if1.busy); end
        step();
        resetl = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL zhw_no_more_c%0d: valid=%0b want 0", c, if1.out_valid); end
        end
        total++; if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL zhw_ready: got %0b want 1", if1.in_ready); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetl = 1'b0;
        if0.in_valid = 1'b0; if0.Value = 64'h0; if0.Rd = 5'd0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.Value = 64'h0; if1.Rd = 5'd0; if1.out_ready = 1'b1;
        step();
        test_reset();
        test_zero();
        test_single();
        test_two();
        test_hold();
        test_back_to_back();
        test_movn();
        test_zero_hw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
